// File: rtl/pwm_timer_ctrl_16.sv
// Control/compare stage for an external 16-bit up counter: period-wrapped PWM,
// wrap pulse, and a double-buffered period/duty config applied on period boundaries.
module pwm_timer_ctrl_16 #(
  parameter logic [15:0] PERIOD_RST = 16'hFFFF,
  parameter logic [15:0] DUTY_RST   = 16'h0000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic        stop,
  input  logic        oneshot,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_period,
  input  logic [15:0] cfg_duty,
  input  logic [15:0] count,
  output logic        cnt_en,
  output logic        cnt_n_clr,
  output logic        pwm_out,
  output logic        wrap_pulse,
  output logic        busy
);

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] period_act, duty_act;
  logic [W-1:0] period_sh, duty_sh;
  logic         pending;
  logic         os_latched;

  logic wrap_hit;
  logic start_acc;
  logic cfg_acc;
  logic xfer;

  // Counter control is combinational so the clear lands on the wrap edge itself.
  assign wrap_hit  = (state != IDLE) && (count == period_act);
  assign start_acc = (state == IDLE) && start;
  assign cfg_acc   = cfg_valid && !pending;
  assign xfer      = pending && (start_acc || wrap_hit);

  assign cnt_en    = (state != IDLE);
  assign cnt_n_clr = !((state == IDLE) || wrap_hit);
  assign cfg_ready = !pending;
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          state_nxt = wrap_hit ? IDLE : STOPPING;
        end else if (wrap_hit && os_latched) begin
          state_nxt = IDLE;
        end
      end
      STOPPING: begin
        if (wrap_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config shadow and active registers; accept and transfer are mutually exclusive via pending.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      period_act <= PERIOD_RST;
      duty_act   <= DUTY_RST;
      period_sh  <= '0;
      duty_sh    <= '0;
      pending    <= 1'b0;
    end else begin
      if (cfg_acc) begin
        period_sh <= cfg_period;
        duty_sh   <= cfg_duty;
        pending   <= 1'b1;
      end else if (xfer) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
        pending    <= 1'b0;
      end
    end
  end

  // Oneshot mode captured at start; registered waveform outputs
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      os_latched <= 1'b0;
      pwm_out    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      if (start_acc) os_latched <= oneshot;
      pwm_out    <= (state != IDLE) && (count < duty_act);
      wrap_pulse <= wrap_hit;
    end
  end

endmodule

// File: tb/tb_pwm_timer_ctrl_16.sv
// Directed bench for pwm_timer_ctrl_16 with a behavioural 16-bit counter in the loop.
module tb_pwm_timer_ctrl_16;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        oneshot = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_duty = '0;
  logic [15:0] count = '0;
  logic        cnt_en;
  logic        cnt_n_clr;
  logic        pwm_out;
  logic        wrap_pulse;
  logic        busy;

  int errors = 0;
  int checks = 0;

  pwm_timer_ctrl_16 dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .start      (start),
    .stop       (stop),
    .oneshot    (oneshot),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .count      (count),
    .cnt_en     (cnt_en),
    .cnt_n_clr  (cnt_n_clr),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // External counter: synchronous active-low clear has priority over enable
  always_ff @(posedge clk) begin
    if (!cnt_n_clr) count <= '0;
    else if (cnt_en) count <= count + 16'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [15:0] p, input logic [15:0] d);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_duty   = d;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic start_run(input logic os);
    start   = 1'b1;
    oneshot = os;
    tick();
    start   = 1'b0;
    oneshot = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc, output int n);
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_count(input string tag, input logic [15:0] v, input int max_cyc);
    int n;
    n = 0;
    while (count != v && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, "_reach"}, 32'(count), 32'(v));
  endtask

  // Hand-computed first ten cycles after start for period=4, duty=2
  logic [9:0] exp_pwm  = 10'b0011000110;   // bit i = cycle i
  logic [9:0] exp_wrap = 10'b0000100000;
  logic [9:0] exp_nclr = 10'b0111101111;
  logic [15:0] exp_cnt [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

  initial begin
    int n, sum_pwm, sum_wrap, sum_busy, max_cnt, nonzero;

    // Reset
    n_reset = 1'b0;
    tick();
    tick();
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_n_clr", 32'(cnt_n_clr), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_wrap", 32'(wrap_pulse), 32'd0);
    n_reset = 1'b1;
    tick();

    // Basic period 4 / duty 2
    send_cfg(16'd4, 16'd2);
    check("t1_pending", 32'(cfg_ready), 32'd0);
    start_run(1'b0);
    check("t1_ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      check($sformatf("t1_cnt%0d", i), 32'(count), 32'(exp_cnt[i]));
      check($sformatf("t1_pwm%0d", i), 32'(pwm_out), 32'(exp_pwm[i]));
      check($sformatf("t1_wrap%0d", i), 32'(wrap_pulse), 32'(exp_wrap[i]));
      check($sformatf("t1_nclr%0d", i), 32'(cnt_n_clr), 32'(exp_nclr[i]));
    end

    // Config update mid-period: held until the count=4 wrap
    wait_count("t2", 16'd1, 10);
    send_cfg(16'd9, 16'd5);
    check("t2_ready_c2", 32'(cfg_ready), 32'd0);
    tick();
    check("t2_ready_c3", 32'(cfg_ready), 32'd0);
    tick();
    check("t2_cnt4", 32'(count), 32'd4);
    check("t2_ready_c4", 32'(cfg_ready), 32'd0);
    tick();
    check("t2_ready_after", 32'(cfg_ready), 32'd1);
    check("t2_wrap_after", 32'(wrap_pulse), 32'd1);
    check("t2_cnt0", 32'(count), 32'd0);
    sum_pwm = 0;
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      sum_pwm += 32'(pwm_out);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    check("t2_high_cycles", 32'(sum_pwm), 32'd5);
    check("t2_max_cnt", 32'(max_cnt), 32'd9);
    check("t2_wrap_end", 32'(wrap_pulse), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_stopping", 32'(busy), 32'd1);
    wait_idle("t2", 20, n);

    // Oneshot: one 4-cycle period then idle
    send_cfg(16'd3, 16'd1);
    start_run(1'b1);
    sum_pwm = 0;
    sum_wrap = 0;
    sum_busy = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sum_pwm  += 32'(pwm_out);
      sum_wrap += 32'(wrap_pulse);
      sum_busy += 32'(busy);
    end
    check("t3_wraps", 32'(sum_wrap), 32'd1);
    check("t3_pwm", 32'(sum_pwm), 32'd1);
    check("t3_busy_cyc", 32'(sum_busy), 32'd3);
    check("t3_cnt_en", 32'(cnt_en), 32'd0);
    check("t3_cnt", 32'(count), 32'd0);

    // Stop at count=1 with period=6; start during STOPPING is ignored
    send_cfg(16'd6, 16'd3);
    start_run(1'b0);
    tick();
    check("t4_cnt1", 32'(count), 32'd1);
    stop = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_cnt3", 32'(count), 32'd3);
    wait_idle("t4", 20, n);
    check("t4_cycles", 32'(n), 32'd4);
    check("t4_wrap", 32'(wrap_pulse), 32'd1);
    check("t4_cnt0", 32'(count), 32'd0);
    tick();
    check("t4_stay_idle", 32'(busy), 32'd0);

    // duty=0: never high
    send_cfg(16'd5, 16'd0);
    start_run(1'b0);
    sum_pwm = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      sum_pwm += 32'(pwm_out);
    end
    check("t5_duty0", 32'(sum_pwm), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("t5a", 20, n);

    // duty > period: always high while running
    send_cfg(16'd7, 16'd8);
    start_run(1'b0);
    sum_pwm = 0;
    sum_wrap = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      sum_pwm  += 32'(pwm_out);
      sum_wrap += 32'(wrap_pulse);
    end
    check("t5_duty_gt", 32'(sum_pwm), 32'd16);
    check("t5_wraps7", 32'(sum_wrap), 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("t5b", 20, n);

    // period=0: wrap every cycle, count pinned at 0; stop on a wrap goes straight to IDLE
    send_cfg(16'd0, 16'd0);
    start_run(1'b0);
    sum_wrap = 0;
    nonzero = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sum_wrap += 32'(wrap_pulse);
      if (count != 16'd0) nonzero++;
    end
    check("t5_p0_wraps", 32'(sum_wrap), 32'd8);
    check("t5_p0_cnt", 32'(nonzero), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_p0_stop", 32'(busy), 32'd0);

    // Reset mid-period with a pending config
    send_cfg(16'd5, 16'd2);
    start_run(1'b0);
    tick();
    send_cfg(16'd9, 16'd9);
    check("t6_pending", 32'(cfg_ready), 32'd0);
    tick();
    check("t6_cnt3", 32'(count), 32'd3);
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_n_clr", 32'(cnt_n_clr), 32'd0);
    check("t6_pwm", 32'(pwm_out), 32'd0);
    check("t6_ready", 32'(cfg_ready), 32'd1);
    check("t6_wrap", 32'(wrap_pulse), 32'd0);
    tick();
    start_run(1'b0);
    sum_pwm = 0;
    sum_wrap = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sum_pwm  += 32'(pwm_out);
      sum_wrap += 32'(wrap_pulse);
    end
    check("t6_rst_period", 32'(count), 32'd6);
    check("t6_rst_duty", 32'(sum_pwm), 32'd0);
    check("t6_no_wrap", 32'(sum_wrap), 32'd0);
    check("t6_ready2", 32'(cfg_ready), 32'd1);
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
